big_ram_wb_arbiter: RTL and testbench

- Round-robin Wishbone (pipelined, with stall) arbiter that shares one big_ram port (A or B) between NUM_MASTERS requesters.
- Grant is locked for the whole bus cycle (cyc held) of the winning master.
- A watchdog forces release and signals err to the granted master if the RAM stops acking.
- One instance is placed in front of each big_ram port.

---
 rtl/big_ram_arb_pkg.sv | 15 +
 rtl/big_ram_wb_arbiter_rr_picker.sv | 35 +++
 rtl/big_ram_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_big_ram_wb_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/big_ram_arb_pkg.sv
// Shared types and default sizing for the big_ram Wishbone arbiter.
// Defaults match one big_ram port.
package big_ram_arb_pkg;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_ADDR_W      = 11;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT     = 255;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/big_ram_wb_arbiter_rr_picker.sv
// Round-robin winner selection.
// Returns the first set request bit found by searching circularly upward from i_ptr.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = '0;
        // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = (int'(i_ptr) + k >= N) ? IDX_W'(int'(i_ptr) + k - N)
                                            : IDX_W'(int'(i_ptr) + k);
            if (i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = w_cand;
                o_onehot         = '0;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/big_ram_wb_arbiter.sv
// Round-robin pipelined-Wishbone arbiter sharing one big_ram port among NUM_MASTERS requesters.
// Grant is held for the winner's whole bus cycle; a no-ack watchdog forces release with an err pulse.
module big_ram_wb_arbiter
    import big_ram_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SEL_W       = DATA_W / 8,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_MASTERS-1:0]        m_wb_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_wb_stb_i,
    input  logic [NUM_MASTERS-1:0]        m_wb_we_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_wb_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wb_data_i,
    input  logic [NUM_MASTERS*SEL_W-1:0]  m_wb_sel_i,
    output logic [NUM_MASTERS-1:0]        m_wb_ack_o,
    output logic [NUM_MASTERS-1:0]        m_wb_stall_o,
    output logic [NUM_MASTERS-1:0]        m_wb_err_o,
    output logic [DATA_W-1:0]             m_wb_data_o,
    output logic                          s_wb_cyc_o,
    output logic                          s_wb_stb_o,
    output logic                          s_wb_we_o,
    output logic [ADDR_W-1:0]             s_wb_addr_o,
    output logic [DATA_W-1:0]             s_wb_data_o,
    output logic [SEL_W-1:0]              s_wb_sel_o,
    input  logic                          s_wb_ack_i,
    input  logic                          s_wb_stall_i,
    input  logic [DATA_W-1:0]             s_wb_data_i,
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] r_lockout;
    logic [NUM_MASTERS-1:0] r_err;
    logic [IDX_W-1:0]       r_gidx;
    logic [IDX_W-1:0]       r_ptr;
    logic [TMR_W-1:0]       r_timer;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_pick_req;
    logic [NUM_MASTERS-1:0] w_win_onehot;
    logic [IDX_W-1:0]       w_win_idx;
    logic [IDX_W-1:0]       w_ptr_next;
    logic                   w_win_valid;
    logic                   w_busy;
    logic                   w_g_cyc;
    logic                   w_release;
    logic                   w_timeout;

    assign w_req     = m_wb_cyc_i & ~r_lockout;
    assign w_busy    = (r_state == ST_GRANT);
    assign w_g_cyc   = w_busy & m_wb_cyc_i[r_gidx];
    assign w_release = w_busy & ~m_wb_cyc_i[r_gidx];
    assign w_timeout = w_g_cyc & ~s_wb_ack_i & (r_timer == TMR_W'(TIMEOUT - 1));

    // While granted, only the other masters compete, so a release hands over without an idle gap.
    assign w_pick_req = w_busy ? (w_req & ~r_grant) : w_req;
    assign w_ptr_next = (w_win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_win_idx + 1'b1;

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req    (w_pick_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    assign s_wb_cyc_o  = w_g_cyc;
    assign s_wb_stb_o  = w_g_cyc & m_wb_stb_i[r_gidx];
    assign s_wb_we_o   = w_g_cyc & m_wb_we_i[r_gidx];
    assign s_wb_addr_o = m_wb_addr_i[r_gidx*ADDR_W +: ADDR_W];
    assign s_wb_data_o = m_wb_data_i[r_gidx*DATA_W +: DATA_W];
    assign s_wb_sel_o  = m_wb_sel_i[r_gidx*SEL_W +: SEL_W];

    assign m_wb_ack_o   = r_grant & {NUM_MASTERS{s_wb_ack_i}};
    assign m_wb_stall_o = ~r_grant | {NUM_MASTERS{s_wb_stall_i}};
    assign m_wb_err_o   = r_err;
    assign m_wb_data_o  = s_wb_data_i;
    assign grant_o      = r_grant;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_lockout <= '0;
            r_err     <= '0;
            r_gidx    <= '0;
            r_ptr     <= '0;
            r_timer   <= '0;
        end else begin
            // NOTE: all state uses non-blocking assignments; later writes to a bit override earlier ones.
            r_err     <= '0;
            r_lockout <= r_lockout & m_wb_cyc_i;
            if (w_timeout) begin
                r_lockout[r_gidx] <= 1'b1;
                r_err[r_gidx]     <= 1'b1;
            end

            if (w_timeout || !w_g_cyc || s_wb_ack_i) begin
                r_timer <= '0;
            end else if (r_timer != TMR_W'(TIMEOUT)) begin
                r_timer <= r_timer + 1'b1;
            end

            if (!w_busy || w_release || w_timeout) begin
                if (w_win_valid) begin
                    r_state <= ST_GRANT;
                    r_grant <= w_win_onehot;
                    r_gidx  <= w_win_idx;
                    r_ptr   <= w_ptr_next;
                end else begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_big_ram_wb_arbiter.sv
// Self-checking bench for big_ram_wb_arbiter: cycle-level master drivers and a RAM stand-in,
// a transaction-level reference model, and a negedge monitor popping expectation queues.
module tb_big_ram_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_ack, m_stall, m_err, grant;
    logic [DW-1:0]   m_rdata;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_sel;
    logic            s_ack, s_stall;
    logic [DW-1:0]   s_rdata;

    big_ram_wb_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SEL_W       (SW),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .m_wb_cyc_i   (m_cyc),
        .m_wb_stb_i   (m_stb),
        .m_wb_we_i    (m_we),
        .m_wb_addr_i  (m_addr),
        .m_wb_data_i  (m_wdata),
        .m_wb_sel_i   (m_sel),
        .m_wb_ack_o   (m_ack),
        .m_wb_stall_o (m_stall),
        .m_wb_err_o   (m_err),
        .m_wb_data_o  (m_rdata),
        .s_wb_cyc_o   (s_cyc),
        .s_wb_stb_o   (s_stb),
        .s_wb_we_o    (s_we),
        .s_wb_addr_o  (s_addr),
        .s_wb_data_o  (s_wdata),
        .s_wb_sel_o   (s_sel),
        .s_wb_ack_i   (s_ack),
        .s_wb_stall_i (s_stall),
        .s_wb_data_i  (s_rdata),
        .grant_o      (grant)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          m;
        bit          we;
        logic [31:0] data;
    } ack_t;

    int   grant_q[$];
    int   err_q[$];
    ack_t ack_q[$];

    logic [31:0] ram       [0:2047];
    logic [31:0] model_mem [0:2047];
    int          model_ptr = 0;
    bit          force_noack = 1'b0;

    logic [N-1:0] smp_acc, smp_ack, smp_err, smp_grant;
    logic [AW-1:0] last_addr;
    logic [SW-1:0] last_sel;

    int          ds [N];
    logic        op_we   [N];
    logic [AW-1:0] op_addr [N];
    logic [31:0] op_data [N];
    logic [3:0]  op_sel  [N];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit any_busy();
        for (int i = 0; i < N; i++) if (ds[i] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_op(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] sel);
        op_we[i] = we; op_addr[i] = a; op_data[i] = d; op_sel[i] = sel;
    endtask

    task automatic start_master(input int i);
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
        m_we[i]  = op_we[i];
        m_addr[i*AW +: AW]  = op_addr[i];
        m_wdata[i*DW +: DW] = op_data[i];
        m_sel[i*SW +: SW]   = op_sel[i];
        ds[i] = 1;
    endtask

    // One clock: sample at negedge, then after the edge update the RAM stand-in and master drivers.
    task automatic cycle();
        logic          r_acc, r_we;
        logic [AW-1:0] r_a;
        logic [31:0]   r_d;
        logic [3:0]    r_s;
        @(negedge clk);
        smp_grant = grant;
        smp_err   = m_err;
        smp_acc   = m_stb & ~m_stall;
        smp_ack   = m_ack;
        r_acc = s_cyc & s_stb & ~s_stall;
        r_we  = s_we; r_a = s_addr; r_d = s_wdata; r_s = s_sel;
        @(posedge clk);
        #1;
        if (smp_err != '0) force_noack = 1'b0;
        s_ack = r_acc & ~force_noack;
        if (r_acc) begin
            last_addr = r_a;
            last_sel  = r_s;
            if (r_we) ram[r_a] = merge(ram[r_a], r_d, r_s);
            else      s_rdata = ram[r_a];
        end
        for (int i = 0; i < N; i++) begin
            case (ds[i])
                1: if (smp_err[i]) begin m_stb[i] = 1'b0; ds[i] = 3; end
                   else if (smp_acc[i]) begin m_stb[i] = 1'b0; ds[i] = 2; end
                2: if (smp_err[i]) ds[i] = 3;
                   else if (smp_ack[i]) begin m_cyc[i] = 1'b0; ds[i] = 0; end
                default: ;
            endcase
        end
    endtask

    // Reference model: simultaneous requesters are served once each in circular order from the pointer.
    task automatic run_round(input logic [N-1:0] mask);
        int idx, last, guard;
        last = model_ptr;
        for (int k = 0; k < N; k++) begin
            idx = (model_ptr + k) % N;
            if (mask[idx]) begin
                grant_q.push_back(idx);
                if (op_we[idx]) begin
                    model_mem[op_addr[idx]] = merge(model_mem[op_addr[idx]], op_data[idx], op_sel[idx]);
                    ack_q.push_back('{m: idx, we: 1'b1, data: 32'h0});
                end else begin
                    ack_q.push_back('{m: idx, we: 1'b0, data: model_mem[op_addr[idx]]});
                end
                last = idx;
            end
        end
        model_ptr = (last + 1) % N;
        for (int i = 0; i < N; i++) if (mask[i]) start_master(i);
        cycle();
        check("arb_wait_stall", 64'(smp_grant), 64'h0);
        cycle();
        check("arb_latency_1cycle", 64'(smp_grant != '0), 64'h1);
        guard = 0;
        while (any_busy() && guard < 200) begin
            cycle();
            guard++;
        end
        if (guard >= 200) check("round_cycle_budget", 64'h0, 64'h1);
        cycle();
    endtask

    logic [N-1:0] prev_grant = '0;

    always @(negedge clk) begin
        int   e;
        ack_t a;
        check("stall_non_granted", 64'(m_stall | grant), 64'hF);
        if (grant != '0 && grant != prev_grant) begin
            if (grant_q.size() == 0) check("grant_unexpected", 64'(grant), 64'h0);
            else begin
                e = grant_q.pop_front();
                check("grant_order", 64'(grant), 64'h1 << e);
            end
        end
        prev_grant = grant;
        if (m_ack != '0) begin
            if (ack_q.size() == 0) check("ack_unexpected", 64'(m_ack), 64'h0);
            else begin
                a = ack_q.pop_front();
                check("ack_master", 64'(m_ack), 64'h1 << a.m);
                if (!a.we) check("read_data", 64'(m_rdata), 64'(a.data));
            end
        end
        if (m_err != '0) begin
            if (err_q.size() == 0) check("err_unexpected", 64'(m_err), 64'h0);
            else begin
                e = err_q.pop_front();
                check("err_pulse", 64'(m_err), 64'h1 << e);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1cnt, guard;
        bit err_seen;
        logic [N-1:0] mask;

        m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_sel = '0;
        s_ack = 1'b0; s_stall = 1'b0; s_rdata = '0;
        for (int i = 0; i < 2048; i++) begin ram[i] = 32'h0; model_mem[i] = 32'h0; end
        for (int i = 0; i < N; i++) ds[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_s_cyc", 64'(s_cyc), 64'h0);
        check("rst_s_stb", 64'(s_stb), 64'h0);
        check("rst_s_we", 64'(s_we), 64'h0);
        check("rst_ack", 64'(m_ack), 64'h0);
        check("rst_err", 64'(m_err), 64'h0);
        check("rst_stall", 64'(m_stall), 64'hF);
        rst_n = 1'b1;
        cycle();

        // Single write then readbacks, byte-select write, cross-master readback.
        set_op(0, 1'b1, 11'd4, 32'hDEADBEEF, 4'hF);  run_round(4'b0001);
        set_op(0, 1'b0, 11'd4, 32'h0, 4'hF);         run_round(4'b0001);
        set_op(2, 1'b1, 11'd48, 32'h00001122, 4'b0011); run_round(4'b0100);
        check("sel_mux", 64'(last_sel), 64'h3);
        check("addr_mux", 64'(last_addr), 64'd48);
        set_op(2, 1'b0, 11'd48, 32'h0, 4'hF);        run_round(4'b0100);
        set_op(3, 1'b0, 11'd4, 32'h0, 4'hF);         run_round(4'b1000);

        // Contention between m0 and m1, then swapped readbacks.
        set_op(0, 1'b1, 11'd8, 32'hAABBCCDD, 4'hF);
        set_op(1, 1'b1, 11'd260, 32'hBEEFCAFE, 4'hF);
        run_round(4'b0011);
        set_op(0, 1'b0, 11'd260, 32'h0, 4'hF);
        set_op(1, 1'b0, 11'd8, 32'h0, 4'hF);
        run_round(4'b0011);

        // Fairness: all four request together, then m0 again.
        set_op(3, 1'b0, 11'd260, 32'h0, 4'hF);       run_round(4'b1000);
        for (int i = 0; i < N; i++) set_op(i, i[0], 11'(16 + i), 32'h1000_0000 + i, 4'hF);
        run_round(4'b1111);
        set_op(0, 1'b0, 11'd17, 32'h0, 4'hF);        run_round(4'b0001);

        // Watchdog: RAM never acks m1's read; m3 waits behind it.
        force_noack = 1'b1;
        grant_q.push_back(1);
        err_q.push_back(1);
        grant_q.push_back(3);
        ack_q.push_back('{m: 3, we: 1'b0, data: model_mem[11'd4]});
        model_ptr = 0;
        set_op(1, 1'b0, 11'd100, 32'h0, 4'hF);
        set_op(3, 1'b0, 11'd4, 32'h0, 4'hF);
        start_master(1);
        g1cnt = 0;
        err_seen = 1'b0;
        for (int c = 0; c < 40 && !err_seen; c++) begin
            cycle();
            if (c == 2) start_master(3);
            if (smp_err[1]) err_seen = 1'b1;
            else if (smp_grant[1]) g1cnt++;
        end
        check("timeout_err_seen", 64'(err_seen), 64'h1);
        check("timeout_granted_cycles", 64'(g1cnt), 64'(TO));
        check("grant_left_m1_on_err", 64'(smp_grant[1]), 64'h0);
        guard = 0;
        while (ds[3] != 0 && guard < 50) begin cycle(); guard++; end
        check("m3_done_after_timeout", 64'(ds[3]), 64'h0);
        repeat (3) cycle();
        check("lockout_holds", 64'(smp_grant), 64'h0);
        m_cyc[1] = 1'b0;
        ds[1] = 0;
        repeat (2) cycle();
        set_op(1, 1'b0, 11'd100, 32'h0, 4'hF);       run_round(4'b0010);

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                set_op(i, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 511)), $urandom,
                       4'($urandom_range(1, 15)));
            run_round(mask);
        end

        // Asynchronous reset in the middle of an m0 write.
        grant_q.push_back(0);
        set_op(0, 1'b1, 11'd2000, 32'h12345678, 4'hF);
        start_master(0);
        cycle();
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_cyc", 64'(s_cyc), 64'h0);
        check("mid_rst_grant", 64'(grant), 64'h0);
        check("mid_rst_ack", 64'(m_ack), 64'h0);
        m_cyc = '0;
        m_stb = '0;
        for (int i = 0; i < N; i++) ds[i] = 0;
        model_ptr = 0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        set_op(1, 1'b0, 11'd8, 32'h0, 4'hF);         run_round(4'b0010);

        repeat (3) cycle();
        check("grant_q_drained", 64'(grant_q.size()), 64'h0);
        check("ack_q_drained", 64'(ack_q.size()), 64'h0);
        check("err_q_drained", 64'(err_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
